// File: rtl/proba_loader.sv
// proba_loader: serial-to-parallel assembler for M-bit probability words.
// Bits arrive in address order (bit 0 first). A word is assembled while the
// previously completed word waits in the output buffer for downstream.
module proba_loader #(
  parameter int unsigned M = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  output logic                 bit_ready,
  output logic [$clog2(M)-1:0] fill_adr,
  output logic [M-1:0]         proba,
  output logic                 proba_valid,
  input  logic                 proba_ready
);

  localparam int unsigned CW = $clog2(M);
  localparam logic [CW-1:0] LAST_ADR = CW'(M - 1);

  // Assembly buffer, fill pointer and output buffer
  logic [M-1:0]  asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [M-1:0]  out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic last_bit;
  logic consume;
  logic acc;
  logic complete;

  // Stall only on the final bit while the output buffer is full and not draining
  always_comb begin
    last_bit  = (cnt_q == LAST_ADR);
    consume   = out_valid_q & proba_ready;
    bit_ready = ~flush & ~(last_bit & out_valid_q & ~proba_ready);
    acc       = bit_valid & bit_ready;
    complete  = acc & last_bit;
  end

  // Next-state: bit capture, word completion, consumption and flush
  always_comb begin
    asm_d       = asm_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (complete) begin
      out_d       = {bit_in, asm_q[M-2:0]};
      out_valid_d = 1'b1;
      cnt_d       = '0;
      asm_d       = '0;
    end else if (acc) begin
      asm_d[cnt_q] = bit_in;
      cnt_d        = cnt_q + CW'(1);
    end
  end

  // State registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign fill_adr    = cnt_q;
  assign proba       = out_q;
  assign proba_valid = out_valid_q;

endmodule

// File: doc/proba_loader.md
# proba_loader

Serial-to-parallel likelihood word assembler for the Bayesian stochastic datapath: the writing end of the bit-selection path. The selecting stage picks `proba[adr]` out of an M-bit probability word. This block builds that word bit by bit, from a serial stream, in address order (bit 0 first). It double-buffers: the next word is assembled while the previous one waits for downstream acceptance.

## Interface
Parameters:
- `M`, default 8: probability word width, in bits. Must be ≥ 2. Counter width is `$clog2(M)`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `flush`, input, 1: synchronous abort of the partially assembled word.
- `bit_valid`, input, 1: `bit_in` is valid this cycle.
- `bit_in`, input, 1: serial probability bit, in address order 0..M-1.
- `bit_ready`, output, 1: the block accepts `bit_in` this cycle.
- `fill_adr`, output, `$clog2(M)`: address that the next accepted bit is written to.
- `proba`, output, M: last completed word; bit k is the k-th bit received.
- `proba_valid`, output, 1: `proba` holds an unconsumed word.
- `proba_ready`, input, 1: downstream consumes `proba` this cycle.

## Operation
- State registers:
  - assembly register `asm_q[M-1:0]`
  - fill counter `cnt_q` (drives `fill_adr`)
  - output register `out_q` (drives `proba`)
  - `out_valid_q` (drives `proba_valid`)
- Bit accept: `acc = bit_valid & bit_ready`.
- `bit_ready = ~flush & ~(cnt_q == M-1 & out_valid_q & ~proba_ready)`.
  - The block stalls only on the final bit of a word, and only while the output buffer is full and not being drained.
- On `acc` with `cnt_q < M-1`:
  - `asm_q[cnt_q] <= bit_in`
  - `cnt_q <= cnt_q + 1`
- On `acc` with `cnt_q == M-1` (word completion):
  - `out_q <= {bit_in, asm_q[M-2:0]}`
  - `out_valid_q <= 1`
  - `cnt_q <= 0`
  - `asm_q <= 0`
- Output consumption: `proba_valid & proba_ready` with no completion in the same cycle → `out_valid_q <= 0`. `out_q` keeps its value; it is don't-care while invalid, but is specified as held.
- Simultaneous completion and consumption: the old word is consumed and the new word is loaded. `proba_valid` stays 1 with no gap.
- `flush` high:
  - `cnt_q <= 0`, `asm_q <= 0`.
  - `bit_ready` is forced 0, so no bit is accepted that cycle.
  - The output register and `proba_valid` are unaffected, and consumption proceeds normally.
- The counter wraps only through completion or flush; it never exceeds M-1.
- `proba_valid` never drops without `proba_ready`. `proba` is stable while `proba_valid & ~proba_ready`.

## Timing
- Reset values (asynchronous, immediate on `rst`):
  - `proba = 0`, `proba_valid = 0`
  - `fill_adr = 0`, `bit_ready = 1` (when `flush = 0`)
  - `asm_q = 0`
- `bit_ready` is combinational from `flush`, `proba_ready` and registered state. No other output is combinational from inputs.
- Latency: `proba`/`proba_valid` update on the edge that accepts bit M-1, so they are visible the cycle after the last bit is presented.
- Throughput: one word per M cycles sustained when `proba_ready` is held high.
- Reset mid-word discards both buffers. The first bit accepted after reset goes to address 0.
- Downstream may hold `proba_ready` high permanently. Upstream may hold `bit_valid` high permanently.

## Test plan
- Reset release with M=8, `proba_ready` = 1, stream 1,0,1,1,0,0,1,0 → on the edge after bit 7: `proba` = 8'h4D, `proba_valid` = 1; `fill_adr` steps 0..7 then 0.
- Backpressure: `proba_ready` = 0, stream word 8'h4D, then 8'hF0 (bits 0,0,0,0,1,1,1,1) → `bit_ready` drops only at `fill_adr` = 7 of the second word; `proba` stays 8'h4D. Raise `proba_ready` for one cycle → last bit accepted the same cycle, `proba` = 8'hF0, `proba_valid` stays 1.
- Simultaneous completion and consumption, back-to-back words with `proba_ready` = 1 → `proba_valid` continuously 1; `proba` changes exactly every 8 cycles.
- Flush after 5 bits (1,1,1,1,1), then stream 0,1,0,0,0,0,0,0 → `proba` = 8'h02 with no residue; a flush asserted in the same cycle as `bit_valid` drops that bit.
- Asynchronous `rst` pulse mid-word (3 bits in) with a pending output 8'h4D → `proba` = 0, `proba_valid` = 0, `fill_adr` = 0 immediately, without waiting for a clock edge.
- M=2 instance: stream 1,0 → `proba` = 2'b01; stream 0,1 → `proba` = 2'b10.
